ex_muldiv_iter: RTL and testbench

//   Parametrised iterative multiply/divide unit beside the EX-stage ALU, for MUL/MULU/DIV/DIVU.

---
 rtl/ex_muldiv_iter.sv | 225 ++++++++++++++++++++++
 tb/tb_ex_muldiv_iter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative multiply/divide unit sitting beside the EX-stage ALU.
// One operand bit is processed per clock. MULU/MUL use shift-add, DIVU/DIV use
// restoring division on magnitudes. The sign fix-up happens in a final FIX cycle,
// which also writes the HI/LO result registers. flush_i squashes an operation in
// flight without touching HI/LO.
module ex_muldiv_iter #(
  parameter int XLEN      = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic            clk_i,
  input  logic            n_rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            div_zero_o
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Two's-complement negation at result width (wraps, so |MIN| stays MIN).
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  // Control registers
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;
  logic             sgn_q;
  logic             sa_q;
  logic             sb_q;
  logic             dz_q;

  // Working registers: hi_w/lo_w hold the running product (mul) or
  // remainder/quotient (div); opnd holds |a| for mul, |b| for div.
  logic [XLEN-1:0]  hi_w_q;
  logic [XLEN-1:0]  lo_w_q;
  logic [XLEN-1:0]  opnd_q;

  // Operand decode at the capture edge
  logic             op_div;
  logic             op_sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             fast_zero;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic             accept;
  logic             write_res;

  assign op_div    = op_i[1];
  assign op_sgn    = op_i[0];
  assign a_neg     = op_sgn & a_i[XLEN-1];
  assign b_neg     = op_sgn & b_i[XLEN-1];
  assign a_abs     = a_neg ? neg_x(a_i) : a_i;
  assign b_abs     = b_neg ? neg_x(b_i) : b_i;
  assign b_zero    = (b_i == '0);
  assign fast_zero = ZERO_FAST & op_div & b_zero;

  assign accept    = (state_q == S_IDLE) & start_i & ~flush_i;
  assign write_res = (state_q == S_FIX) & ~flush_i;
  assign busy_o    = (state_q != S_IDLE);

  // Per-iteration datapath step for both algorithms
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_step;
  logic [XLEN-1:0] lo_step;

  // One shift-add or one restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, hi_w_q} + (lo_w_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_w_q, lo_w_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (div_q) begin
      hi_step = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_step = {lo_w_q[XLEN-2:0], div_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_w_q[XLEN-1:1]};
    end
  end

  // Sign correction applied in the FIX cycle
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   hi_fix;
  logic [XLEN-1:0]   lo_fix;
  logic              sign_diff;

  assign sign_diff = sgn_q & (sa_q ^ sb_q);

  // Final result: negate product/quotient on differing signs, remainder follows dividend
  always_comb begin
    prod_fix = {hi_w_q, lo_w_q};
    hi_fix   = hi_w_q;
    lo_fix   = lo_w_q;
    if (div_q) begin
      hi_fix = (sgn_q & sa_q) ? neg_x(hi_w_q) : hi_w_q;
      if (dz_q) begin
        lo_fix = '1;
      end else begin
        lo_fix = sign_diff ? neg_x(lo_w_q) : lo_w_q;
      end
    end else begin
      if (sign_diff) begin
        prod_fix = neg_2x({hi_w_q, lo_w_q});
      end
      hi_fix = prod_fix[2*XLEN-1:XLEN];
      lo_fix = prod_fix[XLEN-1:0];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush always returns to IDLE and blocks a new start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = fast_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand capture and iteration of the working registers
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      sgn_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      dz_q   <= 1'b0;
      hi_w_q <= '0;
      lo_w_q <= '0;
      opnd_q <= '0;
    end else if (accept) begin
      cnt_q  <= CNT_INIT;
      div_q  <= op_div;
      sgn_q  <= op_sgn;
      sa_q   <= a_neg;
      sb_q   <= b_neg;
      dz_q   <= op_div & b_zero;
      if (op_div) begin
        // Fast divide-by-zero skips RUN; the remainder is the dividend itself.
        hi_w_q <= fast_zero ? a_abs : '0;
        lo_w_q <= a_abs;
        opnd_q <= b_abs;
      end else begin
        hi_w_q <= '0;
        lo_w_q <= b_abs;
        opnd_q <= a_abs;
      end
    end else if ((state_q == S_RUN) && !flush_i) begin
      cnt_q  <= cnt_q - CNT_ONE;
      hi_w_q <= hi_step;
      lo_w_q <= lo_step;
    end
  end

  // Architectural HI/LO, done pulse and sticky divide-by-zero flag
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      hi_o       <= '0;
      lo_o       <= '0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= write_res;
      if (write_res) begin
        hi_o       <= hi_fix;
        lo_o       <= lo_fix;
        div_zero_o <= div_q & dz_q;
      end else if (accept) begin
        div_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Testbench for ex_muldiv_iter (XLEN=32, ZERO_FAST=1): directed cases with literal
// expectations plus randomized operations with flushes, compared every cycle
// against an operation-level reference model.
module tb_ex_muldiv_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      op = 2'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            dz;

  ex_muldiv_iter #(.XLEN(XLEN), .ZERO_FAST(1'b1)) dut (
    .clk_i      (clk),
    .n_rst_i    (n_rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .flush_i    (flush),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo),
    .div_zero_o (dz)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference: the architectural result of one operation, from plain arithmetic.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    longint      lx, ly;
    int          sx, sy;
    rh = '0;
    rl = '0;
    case (o)
      2'd0: begin
        p  = {32'b0, x} * {32'b0, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      2'd1: begin
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        p  = 64'(lx * ly);
        rh = p[63:32];
        rl = p[31:0];
      end
      2'd2: begin
        if (y == 0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: begin
        if (y == 0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rh = 32'h0;
          rl = 32'h8000_0000;
        end else begin
          sx = $signed(x);
          sy = $signed(y);
          rl = 32'(sx / sy);
          rh = 32'(sx % sy);
        end
      end
    endcase
  endtask

  // Cycle-level expectation: remaining busy cycles and pending result of the accepted op.
  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic        m_dz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  logic        p_dz = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
        m_rem  = 0;
        m_done = 1'b0;
        m_dz   = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
      end else begin
        m_done = 1'b0;
        if (m_rem > 0) begin
          if (flush) begin
            m_rem = 0;
          end else begin
            m_rem--;
            if (m_rem == 0) begin
              m_hi   = p_hi;
              m_lo   = p_lo;
              m_dz   = p_dz;
              m_done = 1'b1;
            end
          end
        end else if (start && !flush) begin
          ref_op(op, a, b, p_hi, p_lo);
          p_dz  = op[1] && (b == 0);
          m_dz  = 1'b0;
          m_rem = p_dz ? 1 : XLEN + 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("div_zero", 64'(dz), 64'(m_dz));
    end
  end

  // Issue one op (called at a negedge), wait for done, check latency and literal result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int lat;
    #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
    if (lat != 0) begin
      check({name, "_hi"}, 64'(hi), 64'(eh));
      check({name, "_lo"}, 64'(lo), 64'(el));
      check({name, "_busy_at_done"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rh, rl;
    logic [31:0] x, y;
    int          flush_at;

    // Literal pins of the reference model itself
    ref_op(2'd1, 32'hFFFF_FFFD, 32'd5, rh, rl);
    check("model_mul", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFF1);
    ref_op(2'd3, 32'hFFFF_FFF9, 32'd2, rh, rl);
    check("model_div", {rh, rl}, 64'hFFFF_FFFF_FFFF_FFFD);

    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    #1 n_rst = 1'b1;
    @(negedge clk);

    run_op("mulu_max", 2'd0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 34);
    run_op("mul_neg", 2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
    run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("divu", 2'd2, 32'd7, 32'd2, 32'd1, 32'd3, 34);
    run_op("divu_zero", 2'd2, 32'h100, 32'd0, 32'h100, 32'hFFFF_FFFF, 2);
    check("dz_set", 64'(dz), 64'h1);
    run_op("mulu_clr", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 34);
    check("dz_clear", 64'(dz), 64'h0);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    run_op("mulu_3x4", 2'd0, 32'd3, 32'd4, 32'd0, 32'hC, 34);

    // DIVU squashed in cycle 10
    #1;
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_done", 64'(done), 64'h0);
    check("flush_hi", 64'(hi), 64'h0);
    check("flush_lo", 64'(lo), 64'hC);
    repeat (3) @(negedge clk);

    // start together with flush is not accepted
    #1;
    op = 2'd0; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 64'(busy), 64'h0);

    // Asynchronous reset in cycle 20 of a MUL
    #1;
    op = 2'd1; a = 32'd1234; b = 32'hFFFF_FF00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_done", 64'(done), 64'h0);
    check("arst_dz", 64'(dz), 64'h0);
    @(negedge clk);
    #1 n_rst = 1'b1;
    repeat (40) @(negedge clk);

    // Randomized operations with stray starts and occasional flushes
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: x = 32'h8000_0000;
        1: x = $urandom_range(0, 300);
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      #1;
      op = 2'($urandom_range(0, 3));
      a = x; b = y; start = 1'b1;
      flush = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 34) : 0;
      for (int n = 1; n <= 60; n++) begin
        @(negedge clk);
        if (!busy) break;
        #1;
        flush = (n == flush_at);
        start = ($urandom_range(0, 5) == 0);
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
      end
      start = 1'b0;
      flush = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
